// File: rtl/brick_game_pkg.sv
// Shared definitions for the brick-breaker game engine.
//   state_e  : game phase
//   Ctrl*    : bit positions inside the keypad control nibble
package brick_game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StLost,
    StOver,
    StWin
  } state_e;

  localparam int unsigned CtrlLeft   = 0;
  localparam int unsigned CtrlRight  = 1;
  localparam int unsigned CtrlLaunch = 2;
  localparam int unsigned CtrlPause  = 3;

endpackage

// File: rtl/brick_game_engine_if.sv
// Bus bundle between the game engine and its surroundings.
//   tick/control      : game-step enable and keypad nibble (driven by master)
//   load/load_bricks/
//   load_score        : preload path for brick map and score (driven by master)
//   plate_row .. game_win : registered game state (driven by slave = engine)
interface brick_game_engine_if #(
  parameter int unsigned Cols      = 16,
  parameter int unsigned Rows      = 12,
  parameter int unsigned BrickRows = 6,
  parameter int unsigned ScoreW    = 10
);

  logic                          tick;
  logic [3:0]                    control;
  logic                          load;
  logic [BrickRows*Cols-1:0]     load_bricks;
  logic [ScoreW-1:0]             load_score;

  logic [Cols-1:0]               plate_row;
  logic [$clog2(Rows)-1:0]       ball_row;
  logic [$clog2(Cols)-1:0]       ball_col;
  logic [BrickRows*Cols-1:0]     bricks;
  logic [ScoreW-1:0]             score;
  logic [2:0]                    lives;
  logic                          playing;
  logic                          game_over;
  logic                          game_win;

  modport master (
    output tick, control, load, load_bricks, load_score,
    input  plate_row, ball_row, ball_col, bricks, score, lives, playing, game_over, game_win
  );

  modport slave (
    input  tick, control, load, load_bricks, load_score,
    output plate_row, ball_row, ball_col, bricks, score, lives, playing, game_over, game_win
  );

endinterface

// File: rtl/brick_ball_step.sv
// Combinational single-step ball motion.
//   row_i/col_i/dx_neg_i/dy_neg_i : current ball position and direction (neg = moving -1)
//   bricks_i                      : brick map, bit r*Cols+c
//   plate_pos_i                   : plate left edge as it was before this step
//   row_o/col_o/dx_neg_o/dy_neg_o : ball after the step
//   hit_o/hit_idx_o               : a brick was struck and which bit to clear
//   miss_o                        : ball reached the plate row without the plate under it
module brick_ball_step #(
  parameter int unsigned Cols      = 16,
  parameter int unsigned Rows      = 12,
  parameter int unsigned BrickRows = 6,
  parameter int unsigned PlateW    = 4
) (
  input  logic [$clog2(Rows)-1:0]           row_i,
  input  logic [$clog2(Cols)-1:0]           col_i,
  input  logic                              dx_neg_i,
  input  logic                              dy_neg_i,
  input  logic [BrickRows*Cols-1:0]         bricks_i,
  input  logic [$clog2(Cols)-1:0]           plate_pos_i,
  output logic [$clog2(Rows)-1:0]           row_o,
  output logic [$clog2(Cols)-1:0]           col_o,
  output logic                              dx_neg_o,
  output logic                              dy_neg_o,
  output logic                              hit_o,
  output logic [$clog2(BrickRows*Cols)-1:0] hit_idx_o,
  output logic                              miss_o
);

  localparam int unsigned ColW = $clog2(Cols);
  localparam int unsigned RowW = $clog2(Rows);
  localparam int unsigned IdxW = $clog2(BrickRows*Cols);

  logic [ColW-1:0] nc;
  logic [RowW-1:0] nr;
  logic            ndx;
  logic            ndy;
  logic [IdxW-1:0] bidx;
  logic            in_brick_rows;
  logic            brick_here;
  logic            covered;

  always_comb begin
    // Horizontal: a wall reflect is resolved before any brick test.
    ndx = dx_neg_i;
    if (!dx_neg_i) begin
      if (col_i == ColW'(Cols - 1)) begin
        ndx = 1'b1;
        nc  = col_i - ColW'(1);
      end else begin
        nc  = col_i + ColW'(1);
      end
    end else begin
      if (col_i == '0) begin
        ndx = 1'b0;
        nc  = ColW'(1);
      end else begin
        nc  = col_i - ColW'(1);
      end
    end

    // Vertical: bounce off the top edge.
    ndy = dy_neg_i;
    if (dy_neg_i) begin
      if (row_i == '0) begin
        ndy = 1'b0;
        nr  = RowW'(1);
      end else begin
        nr  = row_i - RowW'(1);
      end
    end else begin
      nr = row_i + RowW'(1);
    end

    in_brick_rows = (32'(nr) < BrickRows);
    bidx          = IdxW'(32'(nr) * Cols + 32'(nc));
    brick_here    = in_brick_rows ? bricks_i[bidx] : 1'b0;
    covered       = (32'(nc) >= 32'(plate_pos_i)) && (32'(nc) < 32'(plate_pos_i) + PlateW);

    row_o     = nr;
    col_o     = nc;
    dx_neg_o  = ndx;
    dy_neg_o  = ndy;
    hit_o     = 1'b0;
    hit_idx_o = bidx;
    miss_o    = 1'b0;

    if (brick_here) begin
      // Ball stays on its row and bounces back from the brick.
      hit_o    = 1'b1;
      dy_neg_o = !ndy;
      row_o    = row_i;
    end else if (nr == RowW'(Rows - 1)) begin
      if (covered) begin
        dy_neg_o = 1'b1;
        row_o    = row_i;
      end else begin
        miss_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/brick_game_engine.sv
// Brick-breaker game-state engine.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset (priority over everything)
//   bus_io : tick/control/preload in, plate/ball/bricks/score/lives/phase flags out.
// All state changes on tick only (or on a preload cycle); outputs come straight from registers.
module brick_game_engine
  import brick_game_pkg::*;
#(
  parameter int unsigned Cols      = 16,
  parameter int unsigned Rows      = 12,
  parameter int unsigned BrickRows = 6,
  parameter int unsigned PlateW    = 4,
  parameter int unsigned Lives     = 3,
  parameter int unsigned ScoreW    = 10,
  parameter int unsigned ScoreMax  = 999
) (
  input  logic                clk_i,
  input  logic                rst_i,
  brick_game_engine_if.slave  bus_io
);

  localparam int unsigned ColW      = $clog2(Cols);
  localparam int unsigned RowW      = $clog2(Rows);
  localparam int unsigned NumBricks = BrickRows * Cols;
  localparam int unsigned IdxW      = $clog2(NumBricks);

  localparam logic [ColW-1:0]   PlateMax    = ColW'(Cols - PlateW);
  localparam logic [ColW-1:0]   PlateInit   = ColW'((Cols - PlateW) / 2);
  localparam logic [ColW-1:0]   PlateHalf   = ColW'(PlateW / 2);
  localparam logic [ColW-1:0]   BallColInit = PlateInit + PlateHalf;
  localparam logic [RowW-1:0]   IdleRow     = RowW'(Rows - 2);
  localparam logic [2:0]        LivesInit   = 3'(Lives);
  localparam logic [ScoreW-1:0] ScoreSat    = ScoreW'(ScoreMax);
  localparam logic [Cols-1:0]   PlateMask   = Cols'((1 << PlateW) - 1);

  state_e                state_q, state_d;
  logic [ColW-1:0]       plate_pos_q, plate_pos_d;
  logic [RowW-1:0]       ball_r_q, ball_r_d;
  logic [ColW-1:0]       ball_c_q, ball_c_d;
  logic                  dx_neg_q, dx_neg_d;
  logic                  dy_neg_q, dy_neg_d;
  logic [NumBricks-1:0]  bricks_q, bricks_d;
  logic [ScoreW-1:0]     score_q, score_d;
  logic [2:0]            lives_q, lives_d;

  logic                  left, right, launch, pause;
  logic [ColW-1:0]       plate_mv;

  logic [RowW-1:0]       step_r;
  logic [ColW-1:0]       step_c;
  logic                  step_dx_neg;
  logic                  step_dy_neg;
  logic                  step_hit;
  logic [IdxW-1:0]       step_idx;
  logic                  step_miss;

  assign left   = bus_io.control[CtrlLeft];
  assign right  = bus_io.control[CtrlRight];
  assign launch = bus_io.control[CtrlLaunch];
  assign pause  = bus_io.control[CtrlPause];

  // Candidate plate position; saturates at both edges.
  always_comb begin
    plate_mv = plate_pos_q;
    if (left && !right && (plate_pos_q != '0)) begin
      plate_mv = plate_pos_q - ColW'(1);
    end else if (right && !left && (plate_pos_q != PlateMax)) begin
      plate_mv = plate_pos_q + ColW'(1);
    end
  end

  // The catch test uses the registered plate, i.e. where the plate was before this tick.
  brick_ball_step #(
    .Cols      (Cols),
    .Rows      (Rows),
    .BrickRows (BrickRows),
    .PlateW    (PlateW)
  ) u_ball_step (
    .row_i       (ball_r_q),
    .col_i       (ball_c_q),
    .dx_neg_i    (dx_neg_q),
    .dy_neg_i    (dy_neg_q),
    .bricks_i    (bricks_q),
    .plate_pos_i (plate_pos_q),
    .row_o       (step_r),
    .col_o       (step_c),
    .dx_neg_o    (step_dx_neg),
    .dy_neg_o    (step_dy_neg),
    .hit_o       (step_hit),
    .hit_idx_o   (step_idx),
    .miss_o      (step_miss)
  );

  always_comb begin
    state_d     = state_q;
    plate_pos_d = plate_pos_q;
    ball_r_d    = ball_r_q;
    ball_c_d    = ball_c_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    bricks_d    = bricks_q;
    score_d     = score_q;
    lives_d     = lives_q;

    if (bus_io.load) begin
      bricks_d = bus_io.load_bricks;
      score_d  = bus_io.load_score;
    end else if (bus_io.tick) begin
      unique case (state_q)
        StIdle: begin
          if (!pause) begin
            plate_pos_d = plate_mv;
          end
          // Ball rides on the plate centre until launched.
          ball_r_d = IdleRow;
          ball_c_d = plate_pos_d + PlateHalf;
          if (launch) begin
            state_d  = StPlay;
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b1;
          end
        end

        StPlay: begin
          if (!pause) begin
            plate_pos_d = plate_mv;
            ball_r_d    = step_r;
            ball_c_d    = step_c;
            dx_neg_d    = step_dx_neg;
            dy_neg_d    = step_dy_neg;
            if (step_hit) begin
              bricks_d = bricks_q & ~(NumBricks'(1) << step_idx);
              if (score_q < ScoreSat) begin
                score_d = score_q + ScoreW'(1);
              end
              if (bricks_d == '0) begin
                state_d = StWin;
              end
            end else if (step_miss) begin
              state_d = StLost;
            end
          end
        end

        StLost: begin
          if (lives_q > 3'd1) begin
            lives_d  = lives_q - 3'd1;
            ball_r_d = IdleRow;
            ball_c_d = plate_pos_q + PlateHalf;
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b1;
            state_d  = StIdle;
          end else begin
            lives_d = '0;
            state_d = StOver;
          end
        end

        StOver, StWin: begin
          if (launch) begin
            state_d     = StIdle;
            plate_pos_d = PlateInit;
            ball_r_d    = IdleRow;
            ball_c_d    = BallColInit;
            dx_neg_d    = 1'b0;
            dy_neg_d    = 1'b1;
            bricks_d    = '1;
            score_d     = '0;
            lives_d     = LivesInit;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      plate_pos_q <= PlateInit;
      ball_r_q    <= IdleRow;
      ball_c_q    <= BallColInit;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b1;
      bricks_q    <= '1;
      score_q     <= '0;
      lives_q     <= LivesInit;
    end else begin
      state_q     <= state_d;
      plate_pos_q <= plate_pos_d;
      ball_r_q    <= ball_r_d;
      ball_c_q    <= ball_c_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      bricks_q    <= bricks_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
    end
  end

  assign bus_io.plate_row = PlateMask << plate_pos_q;
  assign bus_io.ball_row  = ball_r_q;
  assign bus_io.ball_col  = ball_c_q;
  assign bus_io.bricks    = bricks_q;
  assign bus_io.score     = score_q;
  assign bus_io.lives     = lives_q;
  assign bus_io.playing   = (state_q == StPlay);
  assign bus_io.game_over = (state_q == StOver);
  assign bus_io.game_win  = (state_q == StWin);

endmodule

// File: tb/tb_brick_game_engine.sv
// Scoreboard bench for brick_game_engine: every tick (or reset / idle cycle) pushes the
// hand-derived expected game state; a monitor pops and compares after the clock edge.
module tb_brick_game_engine;

  localparam int unsigned Cols = 16, Rows = 12, BrickRows = 6, ScoreW = 10;
  localparam logic [2:0] PhIdle = 3'b000, PhPlay = 3'b001, PhOver = 3'b010, PhWin = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk = 1'b0;
  always #5 clk = ~clk;

  brick_game_engine_if #(.Cols(Cols), .Rows(Rows), .BrickRows(BrickRows), .ScoreW(ScoreW)) bus ();

  brick_game_engine #(
    .Cols(Cols), .Rows(Rows), .BrickRows(BrickRows), .PlateW(4),
    .Lives(3), .ScoreW(ScoreW), .ScoreMax(999)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic [15:0] plate;
    logic [3:0]  r;
    logic [3:0]  c;
    logic [95:0] bricks;
    logic [9:0]  score;
    logic [2:0]  lives;
    logic [2:0]  ph;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Bench-side model of the slowly changing state.
  logic [95:0] bricks_m;
  logic [9:0]  score_m;
  logic [2:0]  lives_m;

  task automatic cmp(input string nm, input string f, input logic [95:0] act,
                     input logic [95:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h, required %0h", nm, f, act, req);
    end
  endtask

  exp_t  mon_e;
  string mon_n;
  always @(posedge clk) begin
    if (chk) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: got empty queue, required an expectation");
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        cmp(mon_n, "plate", 96'(bus.plate_row), 96'(mon_e.plate));
        cmp(mon_n, "row", 96'(bus.ball_row), 96'(mon_e.r));
        cmp(mon_n, "col", 96'(bus.ball_col), 96'(mon_e.c));
        cmp(mon_n, "bricks", bus.bricks, mon_e.bricks);
        cmp(mon_n, "score", 96'(bus.score), 96'(mon_e.score));
        cmp(mon_n, "lives", 96'(bus.lives), 96'(mon_e.lives));
        cmp(mon_n, "phase", 96'({bus.game_win, bus.game_over, bus.playing}), 96'(mon_e.ph));
      end
    end
  end

  task automatic expect_now(input string nm, input int pos, input int r, input int c,
                            input logic [2:0] ph);
    exp_t e;
    e.plate  = 16'h000F << pos;
    e.r      = 4'(r);
    e.c      = 4'(c);
    e.bricks = bricks_m;
    e.score  = score_m;
    e.lives  = lives_m;
    e.ph     = ph;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input logic [3:0] ctrl, input string nm, input int pos, input int r,
                      input int c, input logic [2:0] ph);
    expect_now(nm, pos, r, c, ph);
    @(negedge clk);
    bus.tick = 1'b1; bus.control = ctrl; chk = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0; bus.control = 4'b0000; chk = 1'b0;
  endtask

  task automatic hold(input string nm, input int pos, input int r, input int c,
                      input logic [2:0] ph);
    expect_now(nm, pos, r, c, ph);
    @(negedge clk); chk = 1'b1;
    @(negedge clk); chk = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    bricks_m = '1; score_m = '0; lives_m = 3'd3;
    expect_now(nm, 6, 10, 8, PhIdle);
    @(negedge clk); rst = 1'b1; chk = 1'b1;
    @(negedge clk); rst = 1'b0; chk = 1'b0;
  endtask

  task automatic preload(input logic [95:0] b, input logic [9:0] s);
    bricks_m = b; score_m = s;
    @(negedge clk); bus.load = 1'b1; bus.load_bricks = b; bus.load_score = s;
    @(negedge clk); bus.load = 1'b0;
  endtask

  localparam logic [3:0] CNone = 4'b0000, CLeft = 4'b0001, CRight = 4'b0010;
  localparam logic [3:0] CLaunch = 4'b0100, CPauseR = 4'b1010;

  initial begin
    bus.tick = 1'b0; bus.control = '0; bus.load = 1'b0;
    bus.load_bricks = '0; bus.load_score = '0;
    bricks_m = '1; score_m = '0; lives_m = 3'd3;
    repeat (2) @(negedge clk);

    // Reset state, then no tick -> hold.
    do_reset("reset");
    hold("no_tick", 6, 10, 8, PhIdle);

    // Plate right saturates at pos 12 (16'hF000); IDLE ball follows to col 14.
    for (int i = 1; i <= 10; i++) begin
      int p;
      p = (6 + i > 12) ? 12 : 6 + i;
      step(CRight, "idle_right", p, 10, p + 2, PhIdle);
    end

    // Game 1: launch, climb, hit brick (5,13), reflect off right wall, miss.
    do_reset("reset2");
    step(CLaunch, "g1_launch", 6, 10, 8, PhPlay);
    step(CNone, "g1_p1", 6, 9, 9, PhPlay);
    step(CNone, "g1_p2", 6, 8, 10, PhPlay);
    hold("g1_hold", 6, 8, 10, PhPlay);
    step(CNone, "g1_p3", 6, 7, 11, PhPlay);
    step(CNone, "g1_p4", 6, 6, 12, PhPlay);
    bricks_m[93] = 1'b0; score_m = 10'd1;
    step(CNone, "g1_hit", 6, 6, 13, PhPlay);
    step(CNone, "g1_p6", 6, 7, 14, PhPlay);
    step(CNone, "g1_p7", 6, 8, 15, PhPlay);
    step(CNone, "g1_wall", 6, 9, 14, PhPlay);
    step(CNone, "g1_p9", 6, 10, 13, PhPlay);
    step(CNone, "g1_miss", 6, 11, 12, PhIdle);
    lives_m = 3'd2;
    step(CNone, "g1_lost", 6, 10, 8, PhIdle);

    // Game 2: passes through the cleared cell, hits (4,14), reaches (6,15) and reflects.
    step(CLaunch, "g2_launch", 6, 10, 8, PhPlay);
    step(CNone, "g2_p1", 6, 9, 9, PhPlay);
    step(CNone, "g2_p2", 6, 8, 10, PhPlay);
    step(CNone, "g2_p3", 6, 7, 11, PhPlay);
    step(CNone, "g2_p4", 6, 6, 12, PhPlay);
    step(CNone, "g2_empty_cell", 6, 5, 13, PhPlay);
    bricks_m[78] = 1'b0; score_m = 10'd2;
    step(CNone, "g2_hit", 6, 5, 14, PhPlay);
    step(CNone, "g2_at_15", 6, 6, 15, PhPlay);
    step(CNone, "g2_wall", 6, 7, 14, PhPlay);
    step(CNone, "g2_p9", 6, 8, 13, PhPlay);
    step(CNone, "g2_p10", 6, 9, 12, PhPlay);
    step(CNone, "g2_p11", 6, 10, 11, PhPlay);
    step(CNone, "g2_miss", 6, 11, 10, PhIdle);
    lives_m = 3'd1;
    step(CNone, "g2_lost", 6, 10, 8, PhIdle);

    // Game 3: plate to pos 0 (saturating), launch, hit (5,7), miss -> game over.
    for (int i = 1; i <= 7; i++) begin
      int p;
      p = (6 - i < 0) ? 0 : 6 - i;
      step(CLeft, "idle_left", p, 10, p + 2, PhIdle);
    end
    step(CLaunch, "g3_launch", 0, 10, 2, PhPlay);
    step(CNone, "g3_p1", 0, 9, 3, PhPlay);
    step(CNone, "g3_p2", 0, 8, 4, PhPlay);
    step(CNone, "g3_p3", 0, 7, 5, PhPlay);
    step(CNone, "g3_p4", 0, 6, 6, PhPlay);
    bricks_m[87] = 1'b0; score_m = 10'd3;
    step(CNone, "g3_hit", 0, 6, 7, PhPlay);
    step(CNone, "g3_p6", 0, 7, 8, PhPlay);
    step(CNone, "g3_p7", 0, 8, 9, PhPlay);
    step(CNone, "g3_p8", 0, 9, 10, PhPlay);
    step(CNone, "g3_p9", 0, 10, 11, PhPlay);
    step(CNone, "g3_miss", 0, 11, 12, PhIdle);
    lives_m = 3'd0;
    step(CNone, "g3_over", 0, 11, 12, PhOver);
    step(CRight, "over_frozen", 0, 11, 12, PhOver);
    bricks_m = '1; score_m = '0; lives_m = 3'd3;
    step(CLaunch, "over_restart", 6, 10, 8, PhIdle);

    // Game 4: corner reflect + hit together, plate catch, pause, score saturation.
    step(CRight, "g4_r1", 7, 10, 9, PhIdle);
    step(CRight, "g4_r2", 8, 10, 10, PhIdle);
    step(CRight, "g4_r3", 9, 10, 11, PhIdle);
    step(CLaunch, "g4_launch", 9, 10, 11, PhPlay);
    step(CNone, "g4_p1", 9, 9, 12, PhPlay);
    step(CNone, "g4_p2", 9, 8, 13, PhPlay);
    step(CNone, "g4_p3", 9, 7, 14, PhPlay);
    step(CNone, "g4_p4", 9, 6, 15, PhPlay);
    bricks_m[94] = 1'b0; score_m = 10'd1;
    step(CNone, "g4_wall_hit", 9, 6, 14, PhPlay);
    step(CNone, "g4_p6", 9, 7, 13, PhPlay);
    step(CNone, "g4_p7", 9, 8, 12, PhPlay);
    step(CNone, "g4_p8", 9, 9, 11, PhPlay);
    step(CNone, "g4_p9", 9, 10, 10, PhPlay);
    step(CNone, "g4_catch", 9, 10, 9, PhPlay);
    step(CNone, "g4_p11", 9, 9, 8, PhPlay);
    for (int i = 0; i < 5; i++) step(CPauseR, "g4_pause", 9, 9, 8, PhPlay);
    preload(bricks_m, 10'd999);
    step(CNone, "g4_p12", 9, 8, 7, PhPlay);
    step(CNone, "g4_p13", 9, 7, 6, PhPlay);
    step(CNone, "g4_p14", 9, 6, 5, PhPlay);
    bricks_m[84] = 1'b0;
    step(CNone, "g4_sat_hit", 9, 6, 4, PhPlay);
    do_reset("reset_mid_play");

    // Win: one brick left at (5,13), struck on the fifth play step.
    preload(96'(1) << 93, 10'd0);
    step(CLaunch, "w_launch", 6, 10, 8, PhPlay);
    step(CNone, "w_p1", 6, 9, 9, PhPlay);
    step(CNone, "w_p2", 6, 8, 10, PhPlay);
    step(CNone, "w_p3", 6, 7, 11, PhPlay);
    step(CNone, "w_p4", 6, 6, 12, PhPlay);
    bricks_m = '0; score_m = 10'd1;
    step(CNone, "w_win", 6, 6, 13, PhWin);
    step(CLeft, "w_frozen", 6, 6, 13, PhWin);
    bricks_m = '1; score_m = '0; lives_m = 3'd3;
    step(CLaunch, "w_restart", 6, 10, 8, PhIdle);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
